pmm_mmio_dispatch: RTL and testbench
====================================

Name: pmm_mmio_dispatch

Overview:
- Parametrised memory-mapped front end for the pattern-matching modules (PMMs) on the 32-bit data bus.
- CPU stages a DATA_W-bit pattern word by word, then issues a command naming the target channel and its control word.
- Block holds each command per channel and delivers it over a valid/ready handshake.
- Block captures PMM results and reports pending/done/error status through readable registers.

Parameters:
- N_CH, 4, number of PMM channels (1..8).
- DATA_W, 64, pattern width; multiple of 32, 32..256; DW = DATA_W/32.
- CTRL_W, 16, control word width (1..16).
- RES_W, 32, result width (1..32).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- daddr  in  32  byte address; word index a = daddr[31:2].
- dwdata  in  32  write data.
- dwe  in  4  byte write strobes; nonzero = write cycle.
- dre  in  1  read strobe.
- drdata  out  32  registered read data.
- pmm_valid  out  N_CH  per-channel command valid.
- pmm_ready  in  N_CH  per-channel command accept.
- pmm_data  out  N_CH*DATA_W  per-channel pattern; channel c at [c*DATA_W +: DATA_W].
- pmm_ctrl  out  N_CH*CTRL_W  per-channel control word.
- pmm_res_valid  in  N_CH  one-cycle result strobe.
- pmm_res  in  N_CH*RES_W  per-channel result.

Behaviour:
- Reset (async assert, sync release):
  - Staging buffer, hold registers, result registers, pending, done, ovf, badch, last_cmd all 0.
  - drdata = 0; pmm_valid = 0.
- Address map (word index a):
  - 0..DW-1: STAGE[a], R/W, byte-granular via dwe.
  - DW: CMD. Write bits [7:0] = channel id, [31:16] = control (low CTRL_W bits used). Read returns last_cmd.
  - DW+1: STATUS, read-only bits:
    - [7:0] pending
    - [15:8] done
    - [23:16] ovf
    - [24] badch
    - unused channel bits read 0.
  - DW+1 writes are W1C on done, ovf and badch. Each field clears only if its byte strobe is set.
  - DW+2+c (c < N_CH): RES[c], read-only, zero-extended.
  - Any other address: reads 0; writes ignored.
- Read:
  - When dre=1, drdata loads the selected value at the next edge: 1-cycle latency.
  - When dre=0, drdata holds its value.
  - Reading RES[c] clears done[c] at the same edge.
- Dispatch:
  - Occurs only on a CMD write with dwe == 4'hF. A partial CMD write is ignored entirely and last_cmd is unchanged.
  - Every full CMD write updates last_cmd.
  - ch >= N_CH: set badch; nothing else changes.
  - ch < N_CH, and (pending[ch]==0 or pmm_valid[ch]&pmm_ready[ch] in that cycle):
    - At the edge, hold_data[ch] <= staging buffer, hold_ctrl[ch] <= control, pending[ch] <= 1.
    - The staging buffer is not cleared, so back-to-back commands may reuse it.
  - Otherwise: set ovf[ch]; command dropped; hold registers untouched.
- Handshake:
  - pmm_valid = pending (registered), so first valid is 1 cycle after the CMD write.
  - pmm_data and pmm_ctrl are driven from the hold registers and stay stable while valid.
  - valid&ready at an edge clears pending, unless a new dispatch to that channel occurs at the same edge; then pending stays 1 with the new contents.
  - pmm_ready while not valid is ignored.
- Results:
  - pmm_res_valid[c] at an edge latches pmm_res into RES[c] and sets done[c].
  - If done[c] is already set, RES[c] is overwritten and done[c] stays set.
  - Set wins over clear: res_valid in the same cycle as a RES[c] read or a done W1C leaves done[c]=1. drdata returns the old RES value in that case.
- Reset mid-handshake: pmm_valid drops immediately (async); in-flight command lost.
- One bus access per cycle. If dwe≠0 and dre=1 together, both are performed; a read of the same address returns the pre-write value.

Test Plan:
- Reset, then read STATUS -> drdata=0 one cycle after dre; pmm_valid=0.
- Write STAGE0=0xDEADBEEF, STAGE1=0x01234567, CMD=0xA5A50002, pmm_ready[2]=0 -> next cycle pmm_valid=4'b0100, pmm_data ch2=0x01234567DEADBEEF, pmm_ctrl ch2=0xA5A5, STATUS[7:0]=0x04. Raise ready -> pending[2] clears next edge.
- With ch2 pending, write CMD=0x11110002 -> ovf[2]=1 (STATUS=0x00040004); ch2 hold still 0xA5A5. Write STATUS=0x00FF0000 -> ovf cleared.
- Write CMD with ch=0x09 -> STATUS[24]=1, pmm_valid unchanged. Partial CMD write with dwe=4'b0011 -> no dispatch, last_cmd unchanged.
- Pulse pmm_res_valid[1] with pmm_res=0x0000002A -> STATUS[9]=1. Read RES[1] (a=DW+3) -> drdata=0x2A; done[1] cleared.
- Same cycle as a RES[1] read, pulse res_valid[1] with 0x55 -> drdata = old value, done[1] stays 1, RES[1]=0x55.
- Same cycle as pmm_ready[0] completes ch0, write CMD to ch0 -> no ovf; pmm_valid[0] stays 1 with the new ctrl.
- Assert reset while pmm_valid=1 -> valid drops asynchronously; all STATUS bits read 0 afterwards.

Source files
------------

// File: rtl/pmm_mmio_dispatch.sv
// Memory-mapped command dispatcher for the pattern-matching modules.
// The CPU stages a DATA_W-bit pattern in 32-bit words, then writes a command
// naming a channel and its control word. Each channel holds one command and
// offers it on a valid/ready port; results come back as one-cycle strobes and
// are reported through per-channel result registers and a status word.
//
// Command handshake (per channel c):
//   pmm_valid[c] is a registered copy of pending[c]. pmm_data/pmm_ctrl for
//   channel c come straight from the hold registers and only change when a
//   new command is accepted for that channel. A transfer happens at an edge
//   where pmm_valid[c] & pmm_ready[c]; pmm_ready while not valid is ignored.
//   A command written in the same cycle as a transfer replaces the held one
//   and keeps the channel valid.
module pmm_mmio_dispatch #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16,
  parameter int RES_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              daddr,
  input  logic [31:0]              dwdata,
  input  logic [3:0]               dwe,
  input  logic                     dre,
  output logic [31:0]              drdata,
  output logic [N_CH-1:0]          pmm_valid,
  input  logic [N_CH-1:0]          pmm_ready,
  output logic [N_CH*DATA_W-1:0]   pmm_data,
  output logic [N_CH*CTRL_W-1:0]   pmm_ctrl,
  input  logic [N_CH-1:0]          pmm_res_valid,
  input  logic [N_CH*RES_W-1:0]    pmm_res
);

  localparam int DW = DATA_W / 32;
  localparam logic [29:0] A_CMD    = 30'(DW);
  localparam logic [29:0] A_STATUS = 30'(DW + 1);
  localparam logic [29:0] A_RES0   = 30'(DW + 2);

  logic [29:0]       a;
  logic              unused_addr_lsbs;
  logic [31:0]       stage [DW];
  logic [DATA_W-1:0] stage_flat;
  logic [DATA_W-1:0] hold_data [N_CH];
  logic [CTRL_W-1:0] hold_ctrl [N_CH];
  logic [RES_W-1:0]  res_q [N_CH];
  logic [N_CH-1:0]   pending, done, ovf;
  logic              badch;
  logic [31:0]       last_cmd;

  logic              wr_cycle, cmd_wr, stat_wr, bad_set, badch_clr;
  logic [7:0]        cmd_ch;
  logic [CTRL_W-1:0] cmd_ctrl;
  logic [N_CH-1:0]   xfer, dispatch, ovf_set, ovf_clr, done_clr;
  logic [31:0]       status_word, rd_val;

  assign a                = daddr[31:2];
  assign unused_addr_lsbs = ^daddr[1:0];

  assign wr_cycle  = |dwe;
  assign cmd_wr    = wr_cycle && (a == A_CMD) && (dwe == 4'hF);
  assign stat_wr   = wr_cycle && (a == A_STATUS);
  assign cmd_ch    = dwdata[7:0];
  assign cmd_ctrl  = dwdata[16 +: CTRL_W];
  assign xfer      = pending & pmm_ready;
  assign bad_set   = cmd_wr && (cmd_ch >= 8'(N_CH));
  assign badch_clr = stat_wr && dwe[3] && dwdata[24];

  // Per-channel command acceptance, overflow and status-clear decode.
  always_comb begin
    dispatch = '0;
    ovf_set  = '0;
    ovf_clr  = '0;
    done_clr = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (cmd_wr && (cmd_ch == 8'(c))) begin
        if (!pending[c] || pmm_ready[c]) dispatch[c] = 1'b1;
        else                             ovf_set[c]  = 1'b1;
      end
      ovf_clr[c]  = stat_wr && dwe[2] && dwdata[16 + c];
      done_clr[c] = (stat_wr && dwe[1] && dwdata[8 + c]) ||
                    (dre && (a == A_RES0 + 30'(c)));
    end
  end

  // Flatten the staging words into one pattern, word 0 in the low bits.
  always_comb begin
    stage_flat = '0;
    for (int w = 0; w < DW; w++) stage_flat[w*32 +: 32] = stage[w];
  end

  // Status word; channel bits beyond N_CH read as zero.
  always_comb begin
    status_word           = '0;
    status_word[0 +: N_CH]  = pending;
    status_word[8 +: N_CH]  = done;
    status_word[16 +: N_CH] = ovf;
    status_word[24]         = badch;
  end

  // Read mux over the address map; unmapped words read zero.
  always_comb begin
    rd_val = '0;
    for (int w = 0; w < DW; w++) begin
      if (a == 30'(w)) rd_val = stage[w];
    end
    if (a == A_CMD)    rd_val = last_cmd;
    if (a == A_STATUS) rd_val = status_word;
    for (int c = 0; c < N_CH; c++) begin
      if (a == A_RES0 + 30'(c)) rd_val = 32'(res_q[c]);
    end
  end

  // Byte-granular writes into the staging buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < DW; w++) stage[w] <= '0;
    end else begin
      for (int w = 0; w < DW; w++) begin
        if (wr_cycle && (a == 30'(w))) begin
          for (int b = 0; b < 4; b++) begin
            if (dwe[b]) stage[w][b*8 +: 8] <= dwdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Command capture, per-channel pending/hold state, overflow and bad-channel flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_cmd <= '0;
      pending  <= '0;
      ovf      <= '0;
      badch    <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        hold_data[c] <= '0;
        hold_ctrl[c] <= '0;
      end
    end else begin
      if (cmd_wr) last_cmd <= dwdata;
      if (bad_set)        badch <= 1'b1;
      else if (badch_clr) badch <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        if (dispatch[c]) begin
          hold_data[c] <= stage_flat;
          hold_ctrl[c] <= cmd_ctrl;
          pending[c]   <= 1'b1;
        end else if (xfer[c]) begin
          pending[c]   <= 1'b0;
        end
        if (ovf_set[c])      ovf[c] <= 1'b1;
        else if (ovf_clr[c]) ovf[c] <= 1'b0;
      end
    end
  end

  // Result capture; a new result beats a same-cycle read or W1C of done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done <= '0;
      for (int c = 0; c < N_CH; c++) res_q[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (pmm_res_valid[c]) begin
          res_q[c] <= pmm_res[c*RES_W +: RES_W];
          done[c]  <= 1'b1;
        end else if (done_clr[c]) begin
          done[c]  <= 1'b0;
        end
      end
    end
  end

  // Registered read data, held while no read is in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    drdata <= '0;
    else if (dre) drdata <= rd_val;
  end

  assign pmm_valid = pending;

  for (genvar c = 0; c < N_CH; c++) begin : g_out
    assign pmm_data[c*DATA_W +: DATA_W] = hold_data[c];
    assign pmm_ctrl[c*CTRL_W +: CTRL_W] = hold_ctrl[c];
  end

endmodule

// File: tb/tb_pmm_mmio_dispatch.sv
// Bench for pmm_mmio_dispatch: directed scenarios with fixed expected values,
// then random bus/PMM traffic checked against a transaction-level model.
module tb_pmm_mmio_dispatch;

  localparam int N_CH   = 4;
  localparam int DATA_W = 64;
  localparam int CTRL_W = 16;
  localparam int RES_W  = 32;
  localparam int DW     = DATA_W / 32;

  localparam logic [31:0] AD_ST0    = 32'h00;
  localparam logic [31:0] AD_ST1    = 32'h04;
  localparam logic [31:0] AD_CMD    = 32'h08;
  localparam logic [31:0] AD_STATUS = 32'h0C;
  localparam logic [31:0] AD_RES0   = 32'h10;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [31:0]            daddr, dwdata, drdata;
  logic [3:0]             dwe;
  logic                   dre;
  logic [N_CH-1:0]        pmm_valid, pmm_ready, pmm_res_valid;
  logic [N_CH*DATA_W-1:0] pmm_data;
  logic [N_CH*CTRL_W-1:0] pmm_ctrl;
  logic [N_CH*RES_W-1:0]  pmm_res;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [31:0]       m_stage [DW];
  logic [DATA_W-1:0] m_hold_data [N_CH];
  logic [CTRL_W-1:0] m_hold_ctrl [N_CH];
  logic [RES_W-1:0]  m_res [N_CH];
  logic [N_CH-1:0]   m_pend, m_done, m_ovf;
  logic              m_badch;
  logic [31:0]       m_last_cmd, m_drdata;

  pmm_mmio_dispatch #(.N_CH(N_CH), .DATA_W(DATA_W), .CTRL_W(CTRL_W), .RES_W(RES_W)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .dre(dre),
    .drdata(drdata), .pmm_valid(pmm_valid), .pmm_ready(pmm_ready), .pmm_data(pmm_data),
    .pmm_ctrl(pmm_ctrl), .pmm_res_valid(pmm_res_valid), .pmm_res(pmm_res)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int w = 0; w < DW; w++) m_stage[w] = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_hold_data[c] = '0; m_hold_ctrl[c] = '0; m_res[c] = '0;
    end
    m_pend = '0; m_done = '0; m_ovf = '0; m_badch = 1'b0;
    m_last_cmd = '0; m_drdata = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [29:0] wa);
    int i;
    i = int'(wa);
    if (i < DW) return m_stage[i];
    if (i == DW) return m_last_cmd;
    if (i == DW + 1) return {7'b0, m_badch, 4'b0, m_ovf, 4'b0, m_done, 4'b0, m_pend};
    if (i >= DW + 2 && i < DW + 2 + N_CH) return 32'(m_res[i - DW - 2]);
    return 32'h0;
  endfunction

  task automatic check_model(input string where);
    chk({where, ":pmm_valid"}, 64'(pmm_valid), 64'(m_pend));
    chk({where, ":drdata"}, 64'(drdata), 64'(m_drdata));
    for (int c = 0; c < N_CH; c++) begin
      if (m_pend[c]) begin
        chk($sformatf("%s:data%0d", where, c), pmm_data[c*DATA_W +: DATA_W], m_hold_data[c]);
        chk($sformatf("%s:ctrl%0d", where, c), 64'(pmm_ctrl[c*CTRL_W +: CTRL_W]), 64'(m_hold_ctrl[c]));
      end
    end
  endtask

  task automatic set_idle();
    daddr = '0; dwdata = '0; dwe = '0; dre = 1'b0;
    pmm_ready = '0; pmm_res_valid = '0; pmm_res = '0;
  endtask

  // Driver: one bus/PMM cycle, model updated by the bus/handshake rules, then checked.
  task automatic cyc(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we,
                     input logic re, input logic [N_CH-1:0] rdy, input logic [N_CH-1:0] rv,
                     input logic [N_CH*RES_W-1:0] rdat);
    logic [29:0]     wa;
    logic [31:0]     rd_next;
    logic [N_CH-1:0] old_pend;
    int              ch, i;
    daddr = addr; dwdata = wdata; dwe = we; dre = re;
    pmm_ready = rdy; pmm_res_valid = rv; pmm_res = rdat;
    wa = addr[31:2];
    i  = int'(wa);
    rd_next  = re ? m_read(wa) : m_drdata;
    old_pend = m_pend;
    m_pend   = m_pend & ~(old_pend & rdy);
    if (we == 4'hF && i == DW) begin
      m_last_cmd = wdata;
      ch = int'(wdata[7:0]);
      if (ch >= N_CH) m_badch = 1'b1;
      else if (!old_pend[ch] || rdy[ch]) begin
        for (int w = 0; w < DW; w++) m_hold_data[ch][w*32 +: 32] = m_stage[w];
        m_hold_ctrl[ch] = wdata[16 +: CTRL_W];
        m_pend[ch] = 1'b1;
      end else m_ovf[ch] = 1'b1;
    end
    if (we != 0 && i < DW)
      for (int b = 0; b < 4; b++) if (we[b]) m_stage[i][b*8 +: 8] = wdata[b*8 +: 8];
    if (we != 0 && i == DW + 1) begin
      if (we[1]) m_done = m_done & ~wdata[8 +: N_CH];
      if (we[2]) m_ovf  = m_ovf  & ~wdata[16 +: N_CH];
      if (we[3] && wdata[24]) m_badch = 1'b0;
    end
    if (re && i >= DW + 2 && i < DW + 2 + N_CH) m_done[i - DW - 2] = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (rv[c]) begin
        m_res[c]  = rdat[c*RES_W +: RES_W];
        m_done[c] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_drdata = rd_next;
    set_idle();
    check_model("model");
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
    cyc(addr, wdata, we, 1'b0, '0, '0, '0);
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(addr, 32'h0, 4'h0, 1'b1, '0, '0, '0);
  endtask

  initial begin
    logic [31:0] r_addr, r_data;
    logic [3:0]  r_we;
    logic [N_CH*RES_W-1:0] r_res;

    // Reset
    set_idle();
    reset = 1'b1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_model("reset");
    rd(AD_STATUS);
    chk("reset_status", 64'(drdata), 64'h0);
    chk("reset_valid", 64'(pmm_valid), 64'h0);

    // Stage a pattern and dispatch to channel 2 with ready low
    wr(AD_ST0, 32'hDEADBEEF, 4'hF);
    wr(AD_ST1, 32'h01234567, 4'hF);
    wr(AD_CMD, 32'hA5A50002, 4'hF);
    chk("disp_valid", 64'(pmm_valid), 64'h4);
    chk("disp_data2", pmm_data[2*DATA_W +: DATA_W], 64'h01234567DEADBEEF);
    chk("disp_ctrl2", 64'(pmm_ctrl[2*CTRL_W +: CTRL_W]), 64'hA5A5);
    rd(AD_STATUS);
    chk("disp_status", 64'(drdata), 64'h4);

    // Overflow while pending, then W1C of ovf
    wr(AD_CMD, 32'h11110002, 4'hF);
    rd(AD_STATUS);
    chk("ovf_status", 64'(drdata), 64'h00040004);
    chk("ovf_ctrl2_kept", 64'(pmm_ctrl[2*CTRL_W +: CTRL_W]), 64'hA5A5);
    wr(AD_STATUS, 32'h00FF0000, 4'hF);
    rd(AD_STATUS);
    chk("ovf_cleared", 64'(drdata), 64'h4);
    cyc(32'h0, 32'h0, 4'h0, 1'b0, 4'b0100, '0, '0);
    chk("ready_clears", 64'(pmm_valid), 64'h0);

    // Bad channel and partial command write
    wr(AD_CMD, 32'h00000009, 4'hF);
    chk("badch_valid", 64'(pmm_valid), 64'h0);
    rd(AD_STATUS);
    chk("badch_status", 64'(drdata), 64'h01000000);
    wr(AD_CMD, 32'h22220001, 4'b0011);
    chk("partial_no_disp", 64'(pmm_valid), 64'h0);
    rd(AD_CMD);
    chk("partial_last_cmd", 64'(drdata), 64'h00000009);
    wr(AD_STATUS, 32'h01000000, 4'b1000);
    rd(AD_STATUS);
    chk("badch_w1c", 64'(drdata), 64'h0);

    // Result capture and read-clears-done
    cyc(32'h0, 32'h0, 4'h0, 1'b0, '0, 4'b0010, 128'h0000002A_00000000);
    rd(AD_STATUS);
    chk("done1_set", 64'(drdata), 64'h00000200);
    rd(AD_RES0 + 32'h4);
    chk("res1_read", 64'(drdata), 64'h2A);
    rd(AD_STATUS);
    chk("done1_cleared", 64'(drdata), 64'h0);

    // New result in the same cycle as a RES read
    cyc(AD_RES0 + 32'h4, 32'h0, 4'h0, 1'b1, '0, 4'b0010, 128'h00000055_00000000);
    chk("res1_old_value", 64'(drdata), 64'h2A);
    rd(AD_STATUS);
    chk("done1_set_wins", 64'(drdata), 64'h00000200);
    rd(AD_RES0 + 32'h4);
    chk("res1_new_value", 64'(drdata), 64'h55);

    // Back-to-back dispatch to channel 0 in the transfer cycle
    wr(AD_CMD, 32'h0BAD0000, 4'hF);
    chk("ch0_valid", 64'(pmm_valid), 64'h1);
    cyc(AD_CMD, 32'hC0DE0000, 4'hF, 1'b0, 4'b0001, '0, '0);
    chk("b2b_valid", 64'(pmm_valid), 64'h1);
    chk("b2b_ctrl0", 64'(pmm_ctrl[0 +: CTRL_W]), 64'hC0DE);
    rd(AD_STATUS);
    chk("b2b_no_ovf", 64'(drdata), 64'h1);

    // Reset mid-handshake: valid drops before any clock edge
    #2 reset = 1'b1;
    #1;
    chk("async_reset_valid", 64'(pmm_valid), 64'h0);
    chk("async_reset_drdata", 64'(drdata), 64'h0);
    m_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    check_model("post_reset");
    rd(AD_STATUS);
    chk("post_reset_status", 64'(drdata), 64'h0);
    rd(AD_RES0 + 32'h4);
    chk("post_reset_res1", 64'(drdata), 64'h0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      r_addr = (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
      r_data = $urandom;
      if (r_addr[31:2] == 30'(DW)) r_data[7:0] = 8'($urandom_range(0, 5));
      case ($urandom_range(0, 9))
        0, 1, 2, 3: r_we = 4'h0;
        4, 5, 6, 7: r_we = 4'hF;
        default:    r_we = 4'($urandom_range(0, 15));
      endcase
      r_res = {$urandom, $urandom, $urandom, $urandom};
      cyc(r_addr, r_data, r_we, 1'($urandom_range(0, 1)),
          N_CH'($urandom_range(0, 15)) & N_CH'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0) ? N_CH'($urandom_range(0, 15)) : '0, r_res);
    end

    // Report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
